// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx: parallel-to-serial transmitter. Sends a start bit (0) followed by N data bits on a tri-stated line.
// Latency: the start bit is on dout one cycle after accept. data_sent pulses one cycle after the last line bit. Queued frames follow with no idle gap.
// Backpressure: ready is low while the one-entry holding register is full. At the end-of-frame edge the holding entry refills from dv_in.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   dv_in, din           request strobe and word; a word is taken when dv_in is high and the holding slot is free
//   bit_length           number of data bits N (values above DATA_WIDTH are clamped; 0 is discarded)
//   msb_first            1: din[N-1] .. din[0];  0: din[0] .. din[N-1]
//   ready                holding register empty
//   busy                 a frame is in progress (state not IDLE)
//   dout                 serial line, 1'bz when not driving
//   data_sent            one-cycle pulse at the end of every transmitted frame
// Optional build: define PARALLEL_SERIAL_TX_PARITY_EN to append one even-parity bit after the data bits.

module parallel_serial_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dv_in,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [LEN_WIDTH-1:0]  bit_length,
    input  logic                  msb_first,
    output logic                  ready,
    output logic                  busy,
    output logic                  dout,
    output logic                  data_sent
);

`ifdef PARALLEL_SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_DATA   = 2'd2,
        S_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2
    } state_t;
`endif

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH);

    // Frame currently on the line
    state_t                 state;
    logic [DATA_WIDTH-1:0]  shift_dat;
    logic                   shift_msb;
    logic [LEN_WIDTH-1:0]   bits_left;

    // One-entry holding register for the next frame
    logic                   hold_vld;
    logic [DATA_WIDTH-1:0]  hold_dat;
    logic                   hold_msb;
    logic [LEN_WIDTH-1:0]   hold_len;

    // Registered line and pulse outputs
    logic                   line_oe;
    logic                   line_dat;
    logic                   sent_q;

`ifdef PARALLEL_SERIAL_TX_PARITY_EN
    logic                   par_acc;
`endif

    logic [LEN_WIDTH-1:0]   req_len;
    logic [DATA_WIDTH-1:0]  req_dat;
    logic                   cur_bit;
    logic [DATA_WIDTH-1:0]  shift_nxt;
    logic                   frame_end;
    logic                   accept;
    logic                   take;

    assign req_len = (bit_length > MAX_LEN) ? MAX_LEN : bit_length;

    // MSB-first words are left-aligned so that din[N-1] sits in the top bit.
    // The shifter then always emits from one end and never needs N again.
    assign req_dat = msb_first ? (din << (MAX_LEN - req_len)) : din;

    assign cur_bit   = shift_msb ? shift_dat[DATA_WIDTH-1] : shift_dat[0];
    assign shift_nxt = shift_msb ? (shift_dat << 1) : (shift_dat >> 1);

    // frame_end marks the edge at which the last line bit of the frame stops.
    // Without parity, that is the DATA edge after the counter has run out.
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
    assign frame_end = (state == S_PARITY);
`else
    assign frame_end = (state == S_DATA) && (bits_left == '0);
`endif

    // At the end-of-frame edge the holding entry drains into the shifter.
    // A request on that same edge can therefore refill it, even though ready is low.
    assign accept = dv_in && (!hold_vld || frame_end);
    // Zero-length requests are consumed but leave no trace.
    assign take   = accept && (req_len != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            shift_dat <= '0;
            shift_msb <= 1'b0;
            bits_left <= '0;
            hold_vld  <= 1'b0;
            hold_dat  <= '0;
            hold_msb  <= 1'b0;
            hold_len  <= '0;
            line_oe   <= 1'b0;
            line_dat  <= 1'b0;
            sent_q    <= 1'b0;
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
            par_acc   <= 1'b0;
`endif
        end else begin
            sent_q <= 1'b0;

            if (frame_end) begin
                sent_q <= 1'b1;
                if (hold_vld) begin
                    // Chain directly into the queued frame.
                    // Its start bit goes out on this edge, so DATA follows immediately and no START cycle is spent.
                    shift_dat <= hold_dat;
                    shift_msb <= hold_msb;
                    bits_left <= hold_len;
                    line_oe   <= 1'b1;
                    line_dat  <= 1'b0;
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
                    par_acc   <= 1'b0;
`endif
                    state     <= S_DATA;
                    hold_vld  <= take;
                    if (take) begin
                        hold_dat <= req_dat;
                        hold_msb <= msb_first;
                        hold_len <= req_len;
                    end
                end else begin
                    line_oe <= 1'b0;
                    if (take) begin
                        shift_dat <= req_dat;
                        shift_msb <= msb_first;
                        bits_left <= req_len;
                        state     <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (take) begin
                            shift_dat <= req_dat;
                            shift_msb <= msb_first;
                            bits_left <= req_len;
                            state     <= S_START;
                        end
                    end
                    S_START: begin
                        line_oe  <= 1'b1;
                        line_dat <= 1'b0;
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
                        par_acc  <= 1'b0;
`endif
                        state    <= S_DATA;
                    end
                    S_DATA: begin
                        if (bits_left != '0) begin
                            line_dat  <= cur_bit;
                            shift_dat <= shift_nxt;
                            bits_left <= bits_left - LEN_WIDTH'(1);
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
                            par_acc   <= par_acc ^ cur_bit;
`endif
                        end
`ifdef PARALLEL_SERIAL_TX_PARITY_EN
                        else begin
                            line_dat <= par_acc;
                            state    <= S_PARITY;
                        end
`endif
                    end
                    default: state <= S_IDLE;
                endcase

                // Any request taken while a frame is in progress is queued.
                // In IDLE the holding slot is always empty, and the word goes straight to the shifter instead.
                if (take && (state != S_IDLE)) begin
                    hold_vld <= 1'b1;
                    hold_dat <= req_dat;
                    hold_msb <= msb_first;
                    hold_len <= req_len;
                end
            end
        end
    end

    assign dout      = line_oe ? line_dat : 1'bz;
    assign ready     = !hold_vld;
    assign busy      = (state != S_IDLE);
    assign data_sent = sent_q;

endmodule
